// File: rtl/pid_sched_pkg.sv
// Shared types, default widths and round-robin pick for the PID channel scheduler.
package pid_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } sched_state_e;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 16;
  localparam int unsigned MaxCh = 8;

  // One-hot grant: first pending channel at or above ptr, wrapping modulo n.
  function automatic logic [MaxCh-1:0] rr_pick(input logic [MaxCh-1:0] pend,
                                               input logic [2:0]       ptr,
                                               input int unsigned      n);
    logic [MaxCh-1:0] gnt;
    logic             found;
    logic [2:0]       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxCh; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if ((k < n) && !found && pend[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/pid_channel_scheduler_if.sv
// Handshake and operand/result bus between the scheduler and the shared PID datapath.
interface pid_channel_scheduler_if
  import pid_sched_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) ();

  logic          dp_start;
  logic [DW-1:0] dp_sp;
  logic [DW-1:0] dp_fb;
  logic [AW-1:0] dp_int_in;
  logic [AW-1:0] dp_perr_in;
  logic          dp_done;
  logic [AW-1:0] dp_int_out;
  logic [AW-1:0] dp_perr_out;
  logic [DW-1:0] dp_ctrl;

  modport master (
    output dp_start, dp_sp, dp_fb, dp_int_in, dp_perr_in,
    input  dp_done, dp_int_out, dp_perr_out, dp_ctrl
  );

  modport slave (
    input  dp_start, dp_sp, dp_fb, dp_int_in, dp_perr_in,
    output dp_done, dp_int_out, dp_perr_out, dp_ctrl
  );

endinterface

// File: rtl/pid_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant from pending requests and a search pointer.
module pid_rr_arbiter
  import pid_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         pending_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic [NUM_CH-1:0]         gnt_o
);

  logic [MaxCh-1:0] pend_ext;
  logic [MaxCh-1:0] gnt_ext;
  logic             unused_gnt;

  assign pend_ext   = MaxCh'(pending_i);
  assign gnt_ext    = rr_pick(pend_ext, 3'(ptr_i), NUM_CH);
  assign gnt_o      = gnt_ext[NUM_CH-1:0];
  assign unused_gnt = ^gnt_ext;

endmodule

// File: rtl/pid_channel_scheduler.sv
// Time-shares one PID datapath among NUM_CH loops; holds per-channel context.
// Optional WAIT timeout with sticky err_timeout when PID_SCHED_TIMEOUT_EN is defined.
module pid_channel_scheduler
  import pid_sched_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*DW-1:0]    sp_flat,
  input  logic [NUM_CH*DW-1:0]    fb_flat,
  input  logic                    ctx_clr,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH*DW-1:0]    ctrl_flat,
  output logic                    busy,
  output logic                    err_timeout,
  pid_channel_scheduler_if.master dp
);

  localparam int unsigned   PW     = $clog2(NUM_CH);
  localparam logic [PW-1:0] LastCh = PW'(NUM_CH - 1);

  sched_state_e      state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] gnt_oh;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [PW-1:0]     gnt_idx, ptr_next;
  logic [DW-1:0]     sp_q, sp_d, fb_q, fb_d;
  logic [DW-1:0]     res_ctrl_q, res_ctrl_d;
  logic [AW-1:0]     res_int_q, res_int_d, res_perr_q, res_perr_d;
  logic [AW-1:0]     int_q  [NUM_CH];
  logic [AW-1:0]     int_d  [NUM_CH];
  logic [AW-1:0]     perr_q [NUM_CH];
  logic [AW-1:0]     perr_d [NUM_CH];
  logic [DW-1:0]     ctrl_q [NUM_CH];
  logic [DW-1:0]     ctrl_d [NUM_CH];

`ifdef PID_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  assign err_timeout = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err_timeout    = 1'b0;
`endif

  pid_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .pending_i(pending_q),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt_oh)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_oh[i]) gnt_idx = PW'(i);
    end
  end

  assign ptr_next = (grant_q == LastCh) ? '0 : grant_q + PW'(1);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | req;
    ack_d      = '0;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    sp_d       = sp_q;
    fb_d       = fb_q;
    res_int_d  = res_int_q;
    res_perr_d = res_perr_q;
    res_ctrl_d = res_ctrl_q;
    int_d      = int_q;
    perr_d     = perr_q;
    ctrl_d     = ctrl_q;
`ifdef PID_SCHED_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      StIdle: begin
        if (|pending_q) begin
          grant_d = gnt_idx;
          sp_d    = sp_flat[gnt_idx*DW +: DW];
          fb_d    = fb_flat[gnt_idx*DW +: DW];
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef PID_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        // Results are valid only in the dp_done cycle, so capture them for WB.
        if (dp.dp_done) begin
          res_int_d  = dp.dp_int_out;
          res_perr_d = dp.dp_perr_out;
          res_ctrl_d = dp.dp_ctrl;
          state_d    = StWb;
        end
`ifdef PID_SCHED_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          ptr_d   = ptr_next;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StWb: begin
        int_d[grant_q]     = res_int_q;
        perr_d[grant_q]    = res_perr_q;
        ctrl_d[grant_q]    = res_ctrl_q;
        pending_d[grant_q] = req[grant_q];
        ack_d[grant_q]     = 1'b1;
        ptr_d              = ptr_next;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (ctx_clr) begin
      state_d   = StIdle;
      pending_d = '0;
      ack_d     = '0;
      ptr_d     = ptr_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        int_d[i]  = '0;
        perr_d[i] = '0;
        ctrl_d[i] = '0;
      end
`ifdef PID_SCHED_TIMEOUT_EN
      err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      ack_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      sp_q       <= '0;
      fb_q       <= '0;
      res_int_q  <= '0;
      res_perr_q <= '0;
      res_ctrl_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        int_q[i]  <= '0;
        perr_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
`ifdef PID_SCHED_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      sp_q       <= sp_d;
      fb_q       <= fb_d;
      res_int_q  <= res_int_d;
      res_perr_q <= res_perr_d;
      res_ctrl_q <= res_ctrl_d;
      int_q      <= int_d;
      perr_q     <= perr_d;
      ctrl_q     <= ctrl_d;
`ifdef PID_SCHED_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  assign ack           = ack_q;
  assign busy          = (state_q != StIdle);
  assign dp.dp_start   = (state_q == StIssue);
  assign dp.dp_sp      = sp_q;
  assign dp.dp_fb      = fb_q;
  assign dp.dp_int_in  = int_q[grant_q];
  assign dp.dp_perr_in = perr_q[grant_q];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ctrl
    assign ctrl_flat[g*DW +: DW] = ctrl_q[g];
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed self-checking bench for pid_channel_scheduler with a behavioural datapath responder.
module tb_pid_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctx_clr;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [31:0] sp_flat;
  logic [31:0] fb_flat;
  logic [31:0] ctrl_flat;
  logic        busy;
  logic        err_timeout;

  pid_channel_scheduler_if #(.DW(8), .AW(16)) dp_if ();

  pid_channel_scheduler #(
    .NUM_CH (4),
    .DW     (8),
    .AW     (16),
    .TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .sp_flat    (sp_flat),
    .fb_flat    (fb_flat),
    .ctx_clr    (ctx_clr),
    .ack        (ack),
    .ctrl_flat  (ctrl_flat),
    .busy       (busy),
    .err_timeout(err_timeout),
    .dp         (dp_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Datapath responder settings: lat = cycles from start to done (0 = never answers).
  int          lat    = 1;
  bit          m_incr = 1'b0;
  logic [15:0] m_int  = '0;
  logic [15:0] m_perr = '0;
  logic [7:0]  m_ctrl = '0;

  logic [7:0]  sp_log   [64];
  logic [7:0]  fb_log   [64];
  logic [15:0] int_log  [64];
  logic [15:0] perr_log [64];
  int          start_cyc[64];
  int          n_job = 0;

  logic [3:0]  ack_vec[64];
  int          ack_ch [64];
  int          ack_cyc[64];
  int          n_ack = 0;

  function automatic int oh2idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : dp_model
    int          dn;
    logic [15:0] cur_int;
    logic [15:0] cur_perr;
    dn       = 0;
    cur_int  = '0;
    cur_perr = '0;
    dp_if.dp_done     = 1'b0;
    dp_if.dp_int_out  = '0;
    dp_if.dp_perr_out = '0;
    dp_if.dp_ctrl     = '0;
    forever begin
      @(posedge clk);
      #1;
      dp_if.dp_done = 1'b0;
      if (dn > 0) begin
        dn--;
        if (dn == 0) begin
          dp_if.dp_done     = 1'b1;
          dp_if.dp_int_out  = m_incr ? cur_int + 16'd1 : m_int;
          dp_if.dp_perr_out = m_incr ? cur_perr + 16'd2 : m_perr;
          dp_if.dp_ctrl     = m_incr ? 8'(n_job) : m_ctrl;
        end
      end
      if (dp_if.dp_start === 1'b1) begin
        if (n_job < 64) begin
          sp_log[n_job]    = dp_if.dp_sp;
          fb_log[n_job]    = dp_if.dp_fb;
          int_log[n_job]   = dp_if.dp_int_in;
          perr_log[n_job]  = dp_if.dp_perr_in;
          start_cyc[n_job] = cyc;
        end
        n_job++;
        cur_int  = dp_if.dp_int_in;
        cur_perr = dp_if.dp_perr_in;
        dn       = lat;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (ack !== 4'b0000) begin
      if (n_ack < 64) begin
        ack_vec[n_ack] = ack;
        ack_ch[n_ack]  = oh2idx(ack);
        ack_cyc[n_ack] = cyc;
      end
      n_ack++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_acks(input string tag, input int target, input int bound);
    for (int i = 0; (i < bound) && (n_ack < target); i++) tick();
    check_eq(tag, 32'(n_ack), 32'(target));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    ctx_clr = 1'b0;
    lat     = 1;
    m_incr  = 1'b0;
    repeat (3) tick();
    rst   = 1'b0;
    n_ack = 0;
    n_job = 0;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic pulse_clr();
    ctx_clr = 1'b1;
    tick();
    ctx_clr = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t0;
    int cnt[4];
    sp_flat = 32'h4433_2211;
    fb_flat = 32'h8877_6655;
    rst     = 1'b1;
    req     = '0;
    ctx_clr = 1'b0;
    do_reset();

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_ctrl", ctrl_flat, 32'd0);
    check_eq("rst_err", 32'(err_timeout), 32'd0);
    check_eq("rst_start", 32'(dp_if.dp_start), 32'd0);

    // Single channel, minimum latency.
    m_ctrl = 8'h40;
    m_int  = 16'h0123;
    m_perr = 16'h0011;
    t0     = cyc;
    pulse_req(4'b0100);
    wait_acks("single_ack", 1, 20);
    check_eq("start_lat", 32'(start_cyc[0] - t0), 32'd2);
    check_eq("ack_lat", 32'(ack_cyc[0] - t0), 32'd5);
    check_eq("ack_vec", 32'(ack_vec[0]), 32'b0100);
    check_eq("ack_pulse", 32'(ack), 32'd0);
    check_eq("single_sp", 32'(sp_log[0]), 32'h33);
    check_eq("single_fb", 32'(fb_log[0]), 32'h77);
    check_eq("single_ctrl", ctrl_flat, 32'h0040_0000);
    m_int = 16'h0456;
    pulse_req(4'b0100);
    wait_acks("single_ack2", 2, 20);
    check_eq("ctx2_int", 32'(int_log[1]), 32'h0123);
    check_eq("ctx2_perr", 32'(perr_log[1]), 32'h0011);

    // Context isolation between channels 0 and 3.
    do_reset();
    m_ctrl = 8'h11; m_int = 16'h1000; m_perr = 16'h0A0A;
    pulse_req(4'b0001);
    wait_acks("iso_ack0", 1, 20);
    m_ctrl = 8'h33; m_int = 16'h3000; m_perr = 16'h3333;
    pulse_req(4'b1000);
    wait_acks("iso_ack3", 2, 20);
    m_ctrl = 8'h11; m_int = 16'h1111; m_perr = 16'h0B0B;
    pulse_req(4'b0001);
    wait_acks("iso_ack0b", 3, 20);
    check_eq("iso_ch3_fresh", 32'(int_log[1]), 32'h0000);
    check_eq("iso_ch0_int", 32'(int_log[2]), 32'h1000);
    check_eq("iso_ch0_perr", 32'(perr_log[2]), 32'h0A0A);
    check_eq("iso_ctrl", ctrl_flat, 32'h3300_0011);

    // Request re-pulsed during WB of the same channel.
    do_reset();
    m_ctrl = 8'h21; m_int = 16'h0001; m_perr = 16'h0002;
    pulse_req(4'b0010);
    repeat (3) tick();
    pulse_req(4'b0010);
    wait_acks("resvc_ack", 2, 30);
    check_eq("resvc_ch", 32'(ack_vec[1]), 32'b0010);
    check_eq("resvc_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
    check_eq("resvc_ctx", 32'(int_log[1]), 32'h0001);
    repeat (10) tick();
    check_eq("resvc_drained", 32'(n_ack), 32'd2);

    // ctx_clr while waiting on the datapath.
    do_reset();
    m_ctrl = 8'h55; m_int = 16'h0055; m_perr = 16'h0005;
    pulse_req(4'b0010);
    wait_acks("clr_pre_ack", 1, 20);
    check_eq("clr_pre_ctrl", ctrl_flat, 32'h0000_5500);
    lat = 3;
    m_ctrl = 8'h66;
    pulse_req(4'b0100);
    tick();
    tick();
    check_eq("clr_in_wait", 32'(busy), 32'd1);
    pulse_clr();
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_ctrl", ctrl_flat, 32'd0);
    repeat (10) tick();
    check_eq("clr_no_ack", 32'(n_ack), 32'd1);
    check_eq("clr_ctrl_late", ctrl_flat, 32'd0);
    check_eq("clr_idle", 32'(busy), 32'd0);
    check_eq("clr_no_restart", 32'(n_job), 32'd2);

    // Fairness with all requests held.
    do_reset();
    m_incr = 1'b1;
    req    = 4'b1111;
    wait_acks("rr_acks", 40, 400);
    req = '0;
    cnt = '{0, 0, 0, 0};
    for (int k = 0; k < 40; k++) begin
      check_eq("rr_order", 32'(ack_ch[k]), 32'(k % 4));
      if (ack_ch[k] >= 0) cnt[ack_ch[k]]++;
    end
    for (int c = 0; c < 4; c++) check_eq("rr_count", 32'(cnt[c]), 32'd10);
    check_eq("rr_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
    check_eq("rr_ctx_first", 32'(int_log[0]), 32'd0);
    check_eq("rr_ctx_last", 32'(int_log[39]), 32'd9);
    repeat (40) tick();

`ifdef PID_SCHED_TIMEOUT_EN
    // Datapath never answers: abort after TIMEOUT WAIT cycles.
    do_reset();
    m_ctrl = 8'h5A; m_int = 16'h0777; m_perr = 16'h0070;
    pulse_req(4'b0001);
    wait_acks("to_pre_ack", 1, 20);
    lat = 0;
    pulse_req(4'b0001);
    repeat (16) tick();
    check_eq("to_still_wait", 32'(busy), 32'd1);
    check_eq("to_err_early", 32'(err_timeout), 32'd0);
    tick();
    check_eq("to_idle", 32'(busy), 32'd0);
    check_eq("to_err", 32'(err_timeout), 32'd1);
    lat = 1;
    tick();
    check_eq("to_pending_kept", 32'(dp_if.dp_start), 32'd1);
    check_eq("to_ctrl_kept", ctrl_flat, 32'h0000_005A);
    wait_acks("to_retry_ack", 2, 20);
    check_eq("to_ctx_kept", 32'(int_log[2]), 32'h0777);
    check_eq("to_err_sticky", 32'(err_timeout), 32'd1);
    pulse_clr();
    check_eq("to_err_clr", 32'(err_timeout), 32'd0);
`else
    // Without the timeout the scheduler waits indefinitely.
    do_reset();
    lat = 0;
    pulse_req(4'b0001);
    repeat (40) tick();
    check_eq("nto_busy", 32'(busy), 32'd1);
    check_eq("nto_err", 32'(err_timeout), 32'd0);
    check_eq("nto_no_ack", 32'(n_ack), 32'd0);
    pulse_clr();
    check_eq("nto_clr_idle", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_channel_scheduler.md
Name: pid_channel_scheduler

Overview:
- Time-shares one PID compute datapath (error/integral/derivative engine, 8-bit setpoint/feedback, 16-bit signed internals) among NUM_CH control loops.
- Holds per-channel loop context (integral, prev_error, last 8-bit control output), arbitrates requests round-robin, and sequences start/done with the datapath.
- Writes results back to the serviced channel.
- Sits between the loop sample sources and a single pid datapath instance, so extra loops cost registers only, not arithmetic.

Parameters:
- NUM_CH, 4, number of control loops; 2..8.
- DW, 8, setpoint/feedback/control width.
- AW, 16, signed integral and prev_error width.
- TIMEOUT, 15, max cycles in WAIT before abort; 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_CH  per-channel update request pulse.
- sp_flat  in  NUM_CH*DW  setpoints; channel i at [i*DW +: DW].
- fb_flat  in  NUM_CH*DW  feedbacks; same packing.
- ctx_clr  in  1  pulse: clear all context and pending.
- ack  out  NUM_CH  one-cycle pulse: channel serviced.
- ctrl_flat  out  NUM_CH*DW  registered control outputs per channel.
- busy  out  1  high whenever FSM is not IDLE.
- err_timeout  out  1  sticky abort flag; cleared by rst or ctx_clr.
- dp_start  out  1  one-cycle start to datapath.
- dp_sp, dp_fb  out  DW each  operands of granted channel.
- dp_int_in, dp_perr_in  out  AW each  granted channel context.
- dp_done  in  1  datapath result valid (single cycle).
- dp_int_out, dp_perr_out  in  AW each  updated context.
- dp_ctrl  in  DW  clamped control result.

Behaviour:
- Reset (rst high at posedge): state IDLE, pending=0, all contexts 0, ctrl_flat=0, ack=0, busy=0, err_timeout=0, dp_start=0, RR pointer=0.
- pending[i] is set on any cycle req[i]=1. It is cleared at the WB of channel i, unless req[i]=1 in that same cycle, in which case it stays set.
- FSM states and transitions:
  - IDLE: if pending!=0, register grant (round-robin: search from ptr upward, wrap) and sample sp/fb of that channel -> ISSUE.
  - ISSUE: dp_start=1 for exactly one cycle; dp_* operands held stable from ISSUE through WAIT -> WAIT.
  - WAIT: on dp_done -> WB. A dp_done seen in IDLE or ISSUE is ignored.
  - WB: write dp_int_out/dp_perr_out to ctx[grant]; write dp_ctrl to ctrl_flat[grant]; clear pending[grant]; ptr=grant+1 mod NUM_CH -> IDLE.
- ack[grant] and updated ctrl_flat become visible together, the cycle after WB.
- Minimum latency, with dp_done one cycle after dp_start: req at T -> dp_start at T+2 -> ack at T+5.
- Back-to-back service: IDLE is visited once between jobs.
- ctx_clr is highest priority after rst. In any state it zeroes contexts, ctrl_flat, pending and err_timeout, and forces IDLE with no writeback. ptr is unchanged.
- A req arriving in the same cycle as ctx_clr is dropped.
- Data is stored as returned; no arithmetic in this block. Widths are passed through unchanged.

Optional Feature:
- Macro PID_SCHED_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in WAIT.
  - If TIMEOUT cycles elapse without dp_done: go to IDLE, leave context and ctrl untouched, keep pending[grant] set, advance ptr past grant, set err_timeout.
  - A late dp_done after abort is ignored.
- Undefined:
  - WAIT waits indefinitely; err_timeout is tied 0.

Decomposition:
- Package pid_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, WB}, 2 bits.
  - Default widths DW=8, AW=16.
  - A function that picks the round-robin one-hot grant.
- One sub-module, pid_rr_arbiter: NUM_CH-wide, combinational grant from pending and ptr.
- The context register file stays in the top level.

Test Plan:
- Single channel: req[2] at cycle 10, datapath model returns dp_ctrl=0x40, dp_int_out=0x0123 at done -> ack=0b0100 at cycle 15, ctrl_flat[2]=0x40, ctx2 integral=0x0123.
- Fairness: all req held high for 40 jobs -> grant order 0,1,2,3,0,...; every channel acked exactly 10 times.
- Request during service: req[1] re-pulsed in the same cycle as WB of channel 1 -> pending[1] stays set; channel 1 is serviced again next.
- Context isolation: channel 0 then 3 serviced -> dp_int_in for channel 0's second job equals its own previous dp_int_out, not channel 3's.
- ctx_clr in WAIT: followed by dp_done -> no writeback, no ack; all ctrl_flat=0, busy=0 next cycle.
- PID_SCHED_TIMEOUT_EN defined, TIMEOUT=15, datapath never responds -> returns to IDLE 15 cycles into WAIT, err_timeout=1, pending kept, ctx unchanged.
